updown_decoder: RTL and testbench

Receive-side companion to the up/down counter. Samples the counter's 32-bit `value` bus and recovers the 1-bit instruction stream (0 = up, 1 = down) that produced it. Also counts up and down steps, detects counter resets, and flags illegal steps. Sits beside the counter as a checker/monitor, or at the far end of a link that carries only the counter value.

---
 rtl/updown_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_updown_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_decoder.sv
// -----------------------------------------------------------------------------
// updown_decoder
//
// Receive-side companion to the up/down counter. Watches the counter's 32-bit
// value bus and recovers the 1-bit instruction stream that produced it
// (0 = up, 1 = down). It also keeps up/down step statistics, detects counter
// resets (a jump to 0) and flags illegal steps with a sticky error.
//
// Handshake: value_in is consumed on every rising clock edge where sample_en
// is 1. There is no back-pressure, so one sample per cycle is always accepted.
// The result of a sample accepted at edge N is visible right after edge N.
// inst_valid and resync are single-cycle pulses and are never high together.
//
// Configuration macro:
//   UDDEC_SATURATE_EN  defined   : up_count/down_count saturate at all-ones
//                      undefined : up_count/down_count wrap modulo 2^CNT_W
//
// Parameters:
//   CNT_W        width of the up/down statistics counters
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-low reset
//   clear        synchronous clear of state and statistics (beats sample_en)
//   sample_en    value_in is valid this cycle
//   value_in     counter value sample
//   inst_out     decoded instruction, 0 = up, 1 = down
//   inst_valid   one-cycle pulse, inst_out is valid
//   resync       one-cycle pulse, counter reset detected
//   step_error   sticky, an illegal step was seen
//   locked       decoder is in TRACK
//   up_count     number of decoded up steps
//   down_count   number of decoded down steps
//   dbg_state    current FSM state (0 = IDLE, 1 = TRACK, 2 = ERROR)
// -----------------------------------------------------------------------------
module updown_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [31:0]      value_in,
  output logic             inst_out,
  output logic             inst_valid,
  output logic             resync,
  output logic             step_error,
  output logic             locked,
  output logic [CNT_W-1:0] up_count,
  output logic [CNT_W-1:0] down_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_e           state_q,      state_d;
  logic [31:0]      prev_q,       prev_d;
  logic             inst_out_q,   inst_out_d;
  logic             inst_valid_q, inst_valid_d;
  logic             resync_q,     resync_d;
  logic             step_error_q, step_error_d;
  logic             locked_q,     locked_d;
  logic [CNT_W-1:0] up_q,         up_d;
  logic [CNT_W-1:0] down_q,       down_d;

  // ---------------------------------------------------------------------------
  // Step classification. The subtraction wraps modulo 2^32, which makes
  // FFFF_FFFF -> 0 an up step and 0 -> FFFF_FFFF a down step for free.
  // ---------------------------------------------------------------------------
  logic [31:0] delta;
  logic        step_up;
  logic        step_down;
  logic        jump_zero;

  assign delta     = value_in - prev_q;
  assign step_up   = (delta == 32'd1);
  assign step_down = (delta == 32'hFFFF_FFFF);
  assign jump_zero = (value_in == 32'd0);

  // ---------------------------------------------------------------------------
  // Statistics counter increment, wrapping or saturating
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] up_inc;
  logic [CNT_W-1:0] down_inc;

`ifdef UDDEC_SATURATE_EN
  assign up_inc   = (up_q   == CNT_MAX) ? up_q   : up_q   + CNT_ONE;
  assign down_inc = (down_q == CNT_MAX) ? down_q : down_q + CNT_ONE;
`else
  assign up_inc   = up_q   + CNT_ONE;
  assign down_inc = down_q + CNT_ONE;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    inst_out_d   = inst_out_q;
    inst_valid_d = 1'b0;
    resync_d     = 1'b0;
    step_error_d = step_error_q;
    up_d         = up_q;
    down_d       = down_q;

    if (clear) begin
      // Synchronous return to reset values; any simultaneous sample is dropped.
      state_d      = S_IDLE;
      prev_d       = 32'd0;
      inst_out_d   = 1'b0;
      step_error_d = 1'b0;
      up_d         = '0;
      down_d       = '0;
    end else if (sample_en) begin
      // prev follows the bus in every state.
      prev_d = value_in;
      unique case (state_q)
        S_IDLE: begin
          // First sample only establishes the reference value.
          state_d = S_TRACK;
        end
        S_TRACK: begin
          // Priority order matters: a wrap FFFF_FFFF -> 0 is an up step,
          // not a counter reset.
          if (step_up) begin
            inst_out_d   = 1'b0;
            inst_valid_d = 1'b1;
            up_d         = up_inc;
          end else if (step_down) begin
            inst_out_d   = 1'b1;
            inst_valid_d = 1'b1;
            down_d       = down_inc;
          end else if (jump_zero) begin
            resync_d     = 1'b1;
          end else begin
            step_error_d = 1'b1;
            state_d      = S_ERROR;
          end
        end
        S_ERROR: begin
          // Sticky: only clear or reset leave this state.
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    locked_d = (state_d == S_TRACK);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      prev_q       <= 32'd0;
      inst_out_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      resync_q     <= 1'b0;
      step_error_q <= 1'b0;
      locked_q     <= 1'b0;
      up_q         <= '0;
      down_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
      resync_q     <= resync_d;
      step_error_q <= step_error_d;
      locked_q     <= locked_d;
      up_q         <= up_d;
      down_q       <= down_d;
    end
  end

  assign inst_out   = inst_out_q;
  assign inst_valid = inst_valid_q;
  assign resync     = resync_q;
  assign step_error = step_error_q;
  assign locked     = locked_q;
  assign up_count   = up_q;
  assign down_count = down_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_updown_decoder.sv
// -----------------------------------------------------------------------------
// tb_updown_decoder
//
// Drives two decoders (CNT_W = 16 and CNT_W = 2) with the same sample stream
// and compares them against a behavioural model of the decode rules. Directed
// scenarios come first, then a randomized random-walk of counter values.
// -----------------------------------------------------------------------------
module tb_updown_decoder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        sample_en = 1'b0;
  logic [31:0] value_in = 32'd0;

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic        a_out, a_iv, a_rs, a_err, a_lock;
  logic [15:0] a_up, a_down;
  logic [1:0]  a_dbg;
  logic        b_out, b_iv, b_rs, b_err, b_lock;
  logic [1:0]  b_up, b_down;
  logic [1:0]  b_dbg;

  updown_decoder #(.CNT_W(16)) u_dut16 (
    .clock(clock), .reset(reset), .clear(clear), .sample_en(sample_en),
    .value_in(value_in), .inst_out(a_out), .inst_valid(a_iv), .resync(a_rs),
    .step_error(a_err), .locked(a_lock), .up_count(a_up), .down_count(a_down),
    .dbg_state(a_dbg)
  );

  updown_decoder #(.CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .clear(clear), .sample_en(sample_en),
    .value_in(value_in), .inst_out(b_out), .inst_valid(b_iv), .resync(b_rs),
    .step_error(b_err), .locked(b_lock), .up_count(b_up), .down_count(b_down),
    .dbg_state(b_dbg)
  );

  // ---------------------------------------------------------------------------
  // Reference model: unbounded step counts, converted to counter width on use
  // ---------------------------------------------------------------------------
  bit          m_have_ref;
  bit          m_broken;
  logic [31:0] m_prev;
  int          m_ups;
  int          m_downs;
  bit          e_iv, e_rs, e_out;

  int n_checks = 0;
  int n_errors = 0;

  function automatic int cnt_exp(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
`ifdef UDDEC_SATURATE_EN
    return (n > lim) ? lim : n;
`else
    return n % (1 << w);
`endif
  endfunction

  function automatic void model_reset();
    m_have_ref = 0;
    m_broken   = 0;
    m_prev     = 32'd0;
    m_ups      = 0;
    m_downs    = 0;
    e_iv       = 0;
    e_rs       = 0;
    e_out      = 0;
  endfunction

  function automatic void model_sample(input logic [31:0] v);
    e_iv = 0;
    e_rs = 0;
    if (!m_have_ref) begin
      m_have_ref = 1;
    end else if (!m_broken) begin
      if (v == m_prev + 32'd1) begin
        e_iv = 1; e_out = 0; m_ups++;
      end else if (v == m_prev - 32'd1) begin
        e_iv = 1; e_out = 1; m_downs++;
      end else if (v == 32'd0) begin
        e_rs = 1;
      end else begin
        m_broken = 1;
      end
    end
    m_prev = v;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit chk_out);
    check("inst_valid16", 32'(a_iv),  32'(e_iv));
    check("inst_valid2",  32'(b_iv),  32'(e_iv));
    check("resync16",     32'(a_rs),  32'(e_rs));
    check("resync2",      32'(b_rs),  32'(e_rs));
    check("step_error16", 32'(a_err), 32'(m_broken));
    check("step_error2",  32'(b_err), 32'(m_broken));
    check("locked16",     32'(a_lock), 32'(m_have_ref && !m_broken));
    check("locked2",      32'(b_lock), 32'(m_have_ref && !m_broken));
    check("up_count16",   32'(a_up),   32'(cnt_exp(m_ups, 16)));
    check("down_count16", 32'(a_down), 32'(cnt_exp(m_downs, 16)));
    check("up_count2",    32'(b_up),   32'(cnt_exp(m_ups, 2)));
    check("down_count2",  32'(b_down), 32'(cnt_exp(m_downs, 2)));
    if (chk_out || e_iv) begin
      check("inst_out16", 32'(a_out), 32'(e_out));
      check("inst_out2",  32'(b_out), 32'(e_out));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic send(input logic [31:0] v);
    @(negedge clock);
    sample_en = 1'b1;
    value_in  = v;
    @(posedge clock);
    #1;
    model_sample(v);
    check_all(1'b0);
  endtask

  task automatic idle();
    @(negedge clock);
    sample_en = 1'b0;
    value_in  = $urandom;
    @(posedge clock);
    #1;
    e_iv = 0;
    e_rs = 0;
    check_all(1'b0);
  endtask

  task automatic do_clear(input bit with_sample);
    @(negedge clock);
    clear     = 1'b1;
    sample_en = with_sample;
    value_in  = $urandom;
    @(posedge clock);
    #1;
    clear     = 1'b0;
    sample_en = 1'b0;
    model_reset();
    check_all(1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] cur;
  int          r;

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all(1'b1);               // reset state
    @(negedge clock);
    reset = 1'b1;

    // 5, 6, 7, 6 -> up, up, down
    send(32'd5); send(32'd6); send(32'd7); send(32'd6);
    idle();

    // wrap-around both ways, no resync
    do_clear(1'b0);
    send(32'hFFFF_FFFE); send(32'hFFFF_FFFF); send(32'd0); send(32'hFFFF_FFFF);
    idle();

    // counter reset in the middle of a stream
    do_clear(1'b0);
    send(32'd10); send(32'd11); send(32'd0); send(32'd1);
    idle();

    // repeated value is illegal, error is sticky until clear
    do_clear(1'b0);
    send(32'd3); send(32'd3); send(32'd4); idle();
    do_clear(1'b1);                // sample in the clear cycle is dropped
    send(32'd8); send(32'd9);

    // five up steps exercise the 2-bit counter overflow
    do_clear(1'b0);
    for (int i = 0; i < 6; i++) send(32'd100 + 32'(i));
    idle();

    // asynchronous reset between two accepted samples
    send(32'd200);
    @(negedge clock);
    sample_en = 1'b0;
    #1 reset = 1'b0;
    #2;
    model_reset();
    check_all(1'b1);
    @(negedge clock);
    reset = 1'b1;
    send(32'd20); send(32'd21);
    idle();

    // randomized random walk
    do_clear(1'b0);
    cur = $urandom_range(0, 1) ? 32'hFFFF_FFF8 : 32'd50;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      begin cur = cur + 32'd1; send(cur); end
      else if (r < 82) begin cur = cur - 32'd1; send(cur); end
      else if (r < 87) begin cur = 32'd0;       send(cur); end
      else if (r < 90) begin cur = $urandom;    send(cur); end
      else if (r < 96) idle();
      else begin
        do_clear(1'($urandom_range(0, 1)));
        cur = $urandom_range(0, 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5))
                                   : 32'($urandom_range(0, 5));
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
